chan_mux_arb: RTL and testbench
===============================

CHAN_MUX_ARB -- requirements
Module: chan_mux_arb

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter CHANNELS, default 8, number of input channels; legal range 2..16.
REQ-003 Parameter SEL_WIDTH, default 3, select width; SHALL equal ceil(log2(CHANNELS)).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  CHANNELS  per-channel request; bit i set means data of channel i is offered.
REQ-007 data_in  input  CHANNELS*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 force_en  input  1  bypasses arbitration and selects force_sel, as the legacy 8:1 mux does.
REQ-009 force_sel  input  SEL_WIDTH  channel index used while force_en=1.
REQ-010 grant  output  CHANNELS  combinational one-hot; bit i high in the cycle channel i is captured.
REQ-011 out_valid  output  1  output register holds a valid word.
REQ-012 out_ready  input  1  consumer accepts the word when out_valid=1 and out_ready=1.
REQ-013 out_data  output  WIDTH  registered selected word.
REQ-014 out_sel  output  SEL_WIDTH  registered index of the channel held in out_data.

Function
REQ-015 "Load" SHALL be true when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
REQ-016 On load with force_en=1: capture channel force_sel regardless of req, set out_valid=1, grant=one-hot(force_sel).
REQ-017 On load with force_en=0 and req nonzero: capture the arbitrated winner, set out_valid=1, grant=one-hot(winner).
REQ-018 On load with force_en=0 and req=0: out_valid SHALL go 0, and grant SHALL be 0.
REQ-019 Without load (out_valid=1, out_ready=0): out_data, out_sel and out_valid SHALL hold, and grant SHALL be 0.
REQ-020 Latency: data captured at edge N SHALL appear on out_data after edge N; back-to-back transfers SHALL sustain one word per cycle.
REQ-021 force_sel >= CHANNELS SHALL select channel 0, with out_sel=0.
REQ-022 Two-state machine: EMPTY (out_valid=0) and FULL (out_valid=1); transitions follow REQ-015..019.
REQ-023 Forced captures SHALL NOT update the arbitration pointer.
REQ-024 req and data_in changes while FULL and stalled SHALL NOT affect the held output.

Reset
REQ-025 reset=1 SHALL immediately clear out_valid=0, out_data=0, out_sel=0, and the arbitration pointer to 0.
REQ-026 While reset=1, grant SHALL be 0.
REQ-027 Reset mid-stall SHALL discard the held word, with no grant or replay after reset release.
REQ-028 The first load SHALL be possible on the first rising edge after reset deassertion.

Configuration
REQ-029 Macro CHAN_MUX_ARB_RR_EN: when defined, arbitration SHALL be round-robin: the search starts at pointer p, and after granting channel i the pointer becomes (i+1) mod CHANNELS, wrapping.
REQ-030 Without CHAN_MUX_ARB_RR_EN, arbitration SHALL be fixed priority (lowest requesting index wins), and the pointer logic SHALL be absent.

Verification
REQ-031 Sequence: reset, then force_en=1, force_sel=5, data ch5=16'hBEEF, out_ready=1. Required response: grant=8'h20 in the same cycle; out_data=16'hBEEF, out_sel=5, out_valid=1 after the next edge.
REQ-032 Sequence: RR enabled, req=8'hFF held, out_ready=1 for 10 cycles. Required response: out_sel sequence 0,1,...,7,0,1; exactly one grant bit per cycle.
REQ-033 Sequence: RR disabled, req=8'h14 held. Required response: out_sel=2 every cycle; channel 4 never granted.
REQ-034 Sequence: capture ch3=16'h1234, then out_ready=0 for 4 cycles while data ch3 changes to 16'h0000. Required response: out_data stays 16'h1234, grant=0 throughout, and the transfer completes on out_ready=1.
REQ-035 Sequence: FULL and stalled, assert reset asynchronously mid-cycle. Required response: out_valid=0 and out_data=0 before the next edge; after release with req=0, out_valid stays 0.
REQ-036 Sequence: force_en=1, force_sel=7 with CHANNELS=6, SEL_WIDTH=3. Required response: channel 0 captured, out_sel=0, grant=6'b000001.

Source files
------------

// File: rtl/chan_mux_arb.sv
// Registered N:1 channel mux with arbitration, force override and ready/valid output stage.
// Define CHAN_MUX_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module chan_mux_arb #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CHANNELS  = 8,
    parameter int unsigned SEL_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      force_en,
    input  logic [SEL_WIDTH-1:0]      force_sel,
    output logic [CHANNELS-1:0]       grant,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_WIDTH-1:0]      out_sel
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;

    logic                 load;
    logic                 cap;
    logic                 arb_found;
    logic [SEL_WIDTH-1:0] arb_idx;
    logic [SEL_WIDTH-1:0] force_idx;
    logic [SEL_WIDTH-1:0] cap_idx;

    assign load      = (state_q == EMPTY) || out_ready;
    assign force_idx = (32'(force_sel) < CHANNELS) ? force_sel : '0;

`ifdef CHAN_MUX_ARB_RR_EN
    logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
    logic [CHANNELS-1:0]  req_rot;
    int unsigned          rr_sum;

    // Rotate requests so bit 0 is the pointer position, then take the first hit.
    always_comb begin
        req_rot   = CHANNELS'({req, req} >> ptr_q);
        arb_found = 1'b0;
        arb_idx   = '0;
        rr_sum    = 0;
        for (int unsigned j = 0; j < CHANNELS; j++) begin
            if (!arb_found && req_rot[j]) begin
                arb_found = 1'b1;
                rr_sum    = 32'(ptr_q) + j;
                if (rr_sum >= CHANNELS) begin
                    rr_sum = rr_sum - CHANNELS;
                end
                arb_idx = SEL_WIDTH'(rr_sum);
            end
        end
    end
`else
    // Fixed priority: lowest requesting index wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (!arb_found && req[i]) begin
                arb_found = 1'b1;
                arb_idx   = SEL_WIDTH'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        grant   = '0;
        cap     = 1'b0;
        cap_idx = '0;
`ifdef CHAN_MUX_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        if (load) begin
            if (force_en) begin
                cap     = 1'b1;
                cap_idx = force_idx;
            end else if (arb_found) begin
                cap     = 1'b1;
                cap_idx = arb_idx;
`ifdef CHAN_MUX_ARB_RR_EN
                ptr_d   = (32'(arb_idx) + 1 >= CHANNELS) ? '0
                                                          : SEL_WIDTH'(32'(arb_idx) + 1);
`endif
            end
            state_d = cap ? FULL : EMPTY;
        end
        if (cap) begin
            grant = CHANNELS'(1) << cap_idx;
            sel_d = cap_idx;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (cap_idx == SEL_WIDTH'(i)) begin
                    data_d = data_in[i*WIDTH +: WIDTH];
                end
            end
        end
        // Grant is combinational, so it must be suppressed explicitly while reset is held.
        if (reset) begin
            grant = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
`ifdef CHAN_MUX_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
`ifdef CHAN_MUX_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_chan_mux_arb.sv
// Self-checking bench for chan_mux_arb: vector table plus hand sequences, scoreboard on accepted words.
module tb_chan_mux_arb;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   req = '0;
    logic [127:0] data_in;
    logic         force_en = 1'b0;
    logic [2:0]   force_sel = '0;
    logic [7:0]   grant;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [15:0]  out_data;
    logic [2:0]   out_sel;
    logic [15:0]  ch_data [8];

    logic [5:0]   req6 = '0;
    logic [95:0]  data_in6;
    logic         force_en6 = 1'b0;
    logic [2:0]   force_sel6 = '0;
    logic [5:0]   grant6;
    logic         out_valid6;
    logic         out_ready6 = 1'b0;
    logic [15:0]  out_data6;
    logic [2:0]   out_sel6;
    logic [15:0]  ch6_data [6];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] word;
        logic [2:0]  sel;
    } sb_t;
    sb_t sb_q [$];

    logic        m_valid = 1'b0;
    logic [15:0] m_word  = '0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 8; i++) data_in[i*16 +: 16] = ch_data[i];
        for (int i = 0; i < 6; i++) data_in6[i*16 +: 16] = ch6_data[i];
    end

    chan_mux_arb #(.WIDTH(16), .CHANNELS(8), .SEL_WIDTH(3)) u_dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in),
        .force_en(force_en), .force_sel(force_sel), .grant(grant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel)
    );

    chan_mux_arb #(.WIDTH(16), .CHANNELS(6), .SEL_WIDTH(3)) u_dut6 (
        .clk(clk), .reset(reset), .req(req6), .data_in(data_in6),
        .force_en(force_en6), .force_sel(force_sel6), .grant(grant6),
        .out_valid(out_valid6), .out_ready(out_ready6),
        .out_data(out_data6), .out_sel(out_sel6)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [7:0] oh);
        int r = 0;
        for (int i = 0; i < 8; i++) if (oh[i]) r = i;
        return r;
    endfunction

    // One cycle: drive at negedge, check grant and accepted word before the edge, state after it.
    task automatic step(input string nm, input logic fe, input logic [2:0] fs, input logic [7:0] rq,
                        input logic rdy, input logic [7:0] eg, input logic ev, input logic [2:0] es);
        sb_t e;
        @(negedge clk);
        force_en = fe; force_sel = fs; req = rq; out_ready = rdy;
        #1;
        chk({nm, ".grant"}, 32'(grant), 32'(eg));
        if (m_valid && rdy) begin
            if (sb_q.size() == 0) begin
                chk({nm, ".sb_empty"}, 32'(1), 32'(0));
            end else begin
                e = sb_q.pop_front();
                chk({nm, ".acc_data"}, 32'(out_data), 32'(e.word));
                chk({nm, ".acc_sel"}, 32'(out_sel), 32'(e.sel));
            end
        end
        if (eg != 8'h00) begin
            m_word = ch_data[oh_idx(eg)];
            e.word = m_word;
            e.sel  = es;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        m_valid = ev;
        chk({nm, ".valid"}, 32'(out_valid), 32'(ev));
        if (ev) begin
            chk({nm, ".sel"}, 32'(out_sel), 32'(es));
            chk({nm, ".data"}, 32'(out_data), 32'(m_word));
        end
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk({nm, ".rst_grant"}, 32'(grant), 32'(0));
        chk({nm, ".rst_valid"}, 32'(out_valid), 32'(0));
        chk({nm, ".rst_data"}, 32'(out_data), 32'(0));
        chk({nm, ".rst_sel"}, 32'(out_sel), 32'(0));
        force_en = 1'b0; req = '0; out_ready = 1'b0;
        sb_q.delete();
        m_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic       fe;
        logic [2:0] fs;
        logic [7:0] rq;
        logic       rdy;
        logic [7:0] eg;
        logic       ev;
        logic [2:0] es;
    } vec_t;

    vec_t tbl [14];

    initial begin
        for (int i = 0; i < 8; i++) ch_data[i] = 16'(16'h1111 * (i + 1));
        for (int i = 0; i < 6; i++) ch6_data[i] = 16'(16'hC0D0 + i);

        tbl[0]  = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0};
        tbl[1]  = '{1'b0, 3'd0, 8'h14, 1'b1, 8'h04, 1'b1, 3'd2};
        tbl[2]  = '{1'b0, 3'd0, 8'h10, 1'b1, 8'h10, 1'b1, 3'd4};
        tbl[3]  = '{1'b0, 3'd0, 8'h10, 1'b0, 8'h00, 1'b1, 3'd4};
        tbl[4]  = '{1'b1, 3'd5, 8'h00, 1'b0, 8'h00, 1'b1, 3'd4};
        tbl[5]  = '{1'b1, 3'd5, 8'h00, 1'b1, 8'h20, 1'b1, 3'd5};
        tbl[6]  = '{1'b0, 3'd0, 8'h80, 1'b1, 8'h80, 1'b1, 3'd7};
        tbl[7]  = '{1'b0, 3'd0, 8'h03, 1'b1, 8'h01, 1'b1, 3'd0};
        tbl[8]  = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0};
        tbl[9]  = '{1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0};
        tbl[10] = '{1'b0, 3'd0, 8'h40, 1'b0, 8'h40, 1'b1, 3'd6};
        tbl[11] = '{1'b0, 3'd0, 8'h01, 1'b0, 8'h00, 1'b1, 3'd6};
        tbl[12] = '{1'b1, 3'd3, 8'h00, 1'b1, 8'h08, 1'b1, 3'd3};
`ifdef CHAN_MUX_ARB_RR_EN
        // Pointer sits at 7: the forced capture of channel 3 must not have moved it.
        tbl[13] = '{1'b0, 3'd0, 8'hFF, 1'b1, 8'h80, 1'b1, 3'd7};
`else
        tbl[13] = '{1'b0, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0};
`endif

        do_reset("init");
        for (int i = 0; i < 14; i++) begin
            step($sformatf("vec%0d", i), tbl[i].fe, tbl[i].fs, tbl[i].rq, tbl[i].rdy,
                 tbl[i].eg, tbl[i].ev, tbl[i].es);
        end

        // Forced capture of channel 5 straight after reset.
        do_reset("force");
        ch_data[5] = 16'hBEEF;
        step("force5", 1'b1, 3'd5, 8'h00, 1'b1, 8'h20, 1'b1, 3'd5);
        chk("force5.word", 32'(out_data), 32'(16'hBEEF));

`ifdef CHAN_MUX_ARB_RR_EN
        do_reset("rr");
        for (int i = 0; i < 10; i++) begin
            step($sformatf("rr%0d", i), 1'b0, 3'd0, 8'hFF, 1'b1,
                 8'(8'h01 << (i % 8)), 1'b1, 3'(i % 8));
        end
`else
        do_reset("fp");
        for (int i = 0; i < 4; i++) begin
            step($sformatf("fp%0d", i), 1'b0, 3'd0, 8'h14, 1'b1, 8'h04, 1'b1, 3'd2);
        end
`endif

        // Stall holds the captured word while the source changes.
        do_reset("stall");
        ch_data[3] = 16'h1234;
        step("stall_cap", 1'b0, 3'd0, 8'h08, 1'b1, 8'h08, 1'b1, 3'd3);
        ch_data[3] = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            step($sformatf("stall%0d", i), 1'b0, 3'd0, 8'h08, 1'b0, 8'h00, 1'b1, 3'd3);
            chk($sformatf("stall%0d.word", i), 32'(out_data), 32'(16'h1234));
        end
        step("stall_done", 1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0);
        chk("stall_done.sb", 32'(sb_q.size()), 32'(0));

        // Asynchronous reset mid-stall discards the word.
        ch_data[3] = 16'h5A5A;
        step("ar_cap", 1'b0, 3'd0, 8'h08, 1'b1, 8'h08, 1'b1, 3'd3);
        step("ar_hold", 1'b0, 3'd0, 8'h08, 1'b0, 8'h00, 1'b1, 3'd3);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("ar.valid", 32'(out_valid), 32'(0));
        chk("ar.data", 32'(out_data), 32'(0));
        chk("ar.grant", 32'(grant), 32'(0));
        req = '0; out_ready = 1'b0;
        sb_q.delete();
        m_valid = 1'b0;
        #1;
        reset = 1'b0;
        step("ar_post0", 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0);
        step("ar_post1", 1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0);

        // Six-channel instance: out-of-range force_sel falls back to channel 0.
        @(negedge clk);
        force_en6 = 1'b1; force_sel6 = 3'd7; out_ready6 = 1'b1;
        #1;
        chk("six.grant7", 32'(grant6), 32'(6'b000001));
        @(posedge clk);
        #1;
        chk("six.valid7", 32'(out_valid6), 32'(1));
        chk("six.sel7", 32'(out_sel6), 32'(0));
        chk("six.data7", 32'(out_data6), 32'(16'hC0D0));
        @(negedge clk);
        force_sel6 = 3'd5;
        #1;
        chk("six.grant5", 32'(grant6), 32'(6'b100000));
        @(posedge clk);
        #1;
        chk("six.sel5", 32'(out_sel6), 32'(5));
        chk("six.data5", 32'(out_data6), 32'(16'hC0D5));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
